// File: rtl/br_flow_demux_select_stable_if.sv
// Bundle of push/pop signals for br_flow_demux_select_stable.
// master: producer and consumers (drive push beats and pop_ready).
// slave:  the demux itself.
interface br_flow_demux_select_stable_if #(
    parameter int NumFlows = 2,
    parameter int Width    = 1
);
    localparam int SelWidth = ($clog2(NumFlows) > 1) ? $clog2(NumFlows) : 1;

    logic                           push_ready;
    logic                           push_valid;
    logic [SelWidth-1:0]            push_select;
    logic [Width-1:0]               push_data;
    logic [NumFlows-1:0]            pop_ready;
    logic [NumFlows-1:0]            pop_valid;
    logic [NumFlows-1:0][Width-1:0] pop_data;
    logic                           drop;

    modport master (
        input  push_ready,
        output push_valid,
        output push_select,
        output push_data,
        output pop_ready,
        input  pop_valid,
        input  pop_data,
        input  drop
    );

    modport slave (
        output push_ready,
        input  push_valid,
        input  push_select,
        input  push_data,
        input  pop_ready,
        output pop_valid,
        output pop_data,
        output drop
    );
endinterface

// File: rtl/br_flow_demux_select_stable.sv
// Stable flow demux: one push flow steered to one of NumFlows pop flows by a
// per-beat select. Every output owns its register (or 2-entry skid buffer when
// RegisterPopReady=1), so a stalled output never blocks beats for the others.
// Optional macro BR_FLOW_DEMUX_SELECT_STABLE_DROP_EN: out-of-range selects are
// accepted and discarded with a one-cycle registered drop pulse; without it,
// out-of-range selects are never accepted and drop is tied low.
module br_flow_demux_select_stable #(
    parameter int NumFlows                  = 2,
    parameter int Width                     = 1,
    parameter int RegisterPopReady          = 0,
    parameter int EnableAssertPushDataKnown = 1,
    parameter int EnableAssertFinalNotValid = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    br_flow_demux_select_stable_if.slave  io
);
    localparam int SelWidth = ($clog2(NumFlows) > 1) ? $clog2(NumFlows) : 1;

    logic [NumFlows-1:0]            sel_onehot_s;
    logic [NumFlows-1:0]            can_accept_s;
    logic [NumFlows-1:0]            wr_en_s;
    logic                           in_range_s;
    logic                           drop_accept_s;
    logic                           push_ready_s;
    logic                           push_xfer_s;
    logic [NumFlows-1:0]            head_valid_r;
    logic [NumFlows-1:0][Width-1:0] head_data_r;

    // Decode the select; an index with no matching output is out of range.
    always_comb begin
        sel_onehot_s = '0;
        for (int i = 0; i < NumFlows; i++) begin
            sel_onehot_s[i] = (io.push_select == SelWidth'(i));
        end
        in_range_s = |sel_onehot_s;
    end

`ifdef BR_FLOW_DEMUX_SELECT_STABLE_DROP_EN
    assign drop_accept_s = !in_range_s;
`else
    assign drop_accept_s = 1'b0;
`endif

    // Ready only for the selected output's free slot (or a droppable beat); low in reset.
    always_comb begin
        if (rst) begin
            push_ready_s = 1'b0;
        end else begin
            push_ready_s = (|(sel_onehot_s & can_accept_s)) || drop_accept_s;
        end
    end

    assign push_xfer_s = io.push_valid && push_ready_s;
    assign wr_en_s     = sel_onehot_s & {NumFlows{push_xfer_s}};

    generate
        if (RegisterPopReady != 0) begin : g_skid
            logic [NumFlows-1:0]            tail_valid_r;
            logic [NumFlows-1:0][Width-1:0] tail_data_r;
            logic [NumFlows-1:0]            pop_s;

            // Accept depends on registered occupancy only: no pop_ready to push_ready path.
            assign can_accept_s = ~tail_valid_r;
            assign pop_s        = head_valid_r & io.pop_ready;

            // Per-output 2-entry skid buffer; head drives the pop side.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    head_valid_r <= '0;
                    head_data_r  <= '0;
                    tail_valid_r <= '0;
                    tail_data_r  <= '0;
                end else begin
                    for (int i = 0; i < NumFlows; i++) begin
                        case ({pop_s[i], wr_en_s[i]})
                            2'b11: begin
                                // Tail is empty whenever a write is allowed: reload head.
                                head_data_r[i] <= io.push_data;
                            end
                            2'b10: begin
                                if (tail_valid_r[i]) begin
                                    head_data_r[i]  <= tail_data_r[i];
                                    tail_valid_r[i] <= 1'b0;
                                end else begin
                                    head_valid_r[i] <= 1'b0;
                                end
                            end
                            2'b01: begin
                                if (head_valid_r[i]) begin
                                    tail_data_r[i]  <= io.push_data;
                                    tail_valid_r[i] <= 1'b1;
                                end else begin
                                    head_data_r[i]  <= io.push_data;
                                    head_valid_r[i] <= 1'b1;
                                end
                            end
                            default: begin
                                head_valid_r[i] <= head_valid_r[i];
                            end
                        endcase
                    end
                end
            end
        end else begin : g_single
            // A slot frees up in the same cycle its current beat is popped.
            assign can_accept_s = ~head_valid_r | io.pop_ready;

            // Per-output single register; simultaneous pop and push reload it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    head_valid_r <= '0;
                    head_data_r  <= '0;
                end else begin
                    for (int i = 0; i < NumFlows; i++) begin
                        if (wr_en_s[i]) begin
                            head_valid_r[i] <= 1'b1;
                            head_data_r[i]  <= io.push_data;
                        end else if (io.pop_ready[i]) begin
                            head_valid_r[i] <= 1'b0;
                        end else begin
                            head_valid_r[i] <= head_valid_r[i];
                        end
                    end
                end
            end
        end
    endgenerate

`ifdef BR_FLOW_DEMUX_SELECT_STABLE_DROP_EN
    logic drop_r;

    // One-cycle pulse after an out-of-range beat is swallowed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_r <= 1'b0;
        end else begin
            drop_r <= push_xfer_s && !in_range_s;
        end
    end

    assign io.drop = drop_r;
`else
    assign io.drop = 1'b0;
`endif

    assign io.push_ready = push_ready_s;
    assign io.pop_valid  = head_valid_r;
    assign io.pop_data   = head_data_r;

`ifndef SYNTHESIS
    br_flow_demux_select_stable_chk #(
        .NumFlows                  (NumFlows),
        .Width                     (Width),
        .EnableAssertPushDataKnown (EnableAssertPushDataKnown),
        .EnableAssertFinalNotValid (EnableAssertFinalNotValid)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .push_valid  (io.push_valid),
        .push_ready  (push_ready_s),
        .push_select (io.push_select),
        .push_data   (io.push_data),
        .pop_ready   (io.pop_ready),
        .pop_valid   (head_valid_r),
        .pop_data    (head_data_r),
        .in_range    (in_range_s)
    );
`endif
endmodule

// Protocol checks on both sides of the demux.
module br_flow_demux_select_stable_chk #(
    parameter int NumFlows                  = 2,
    parameter int Width                     = 1,
    parameter int EnableAssertPushDataKnown = 1,
    parameter int EnableAssertFinalNotValid = 1,
    localparam int SelWidth = ($clog2(NumFlows) > 1) ? $clog2(NumFlows) : 1
) (
    input logic                           clk,
    input logic                           rst,
    input logic                           push_valid,
    input logic                           push_ready,
    input logic [SelWidth-1:0]            push_select,
    input logic [Width-1:0]               push_data,
    input logic [NumFlows-1:0]            pop_ready,
    input logic [NumFlows-1:0]            pop_valid,
    input logic [NumFlows-1:0][Width-1:0] pop_data,
    input logic                           in_range
);
    a_push_hold: assert property (@(posedge clk) disable iff (rst)
        push_valid && !push_ready |=> push_valid && $stable(push_select) && $stable(push_data));

    generate
        if (EnableAssertPushDataKnown != 0) begin : g_known
            a_push_known: assert property (@(posedge clk) disable iff (rst)
                push_valid |-> !$isunknown(push_data));
        end
        for (genvar g = 0; g < NumFlows; g++) begin : g_pop
            a_pop_stable: assert property (@(posedge clk) disable iff (rst)
                pop_valid[g] && !pop_ready[g] |=> pop_valid[g] && $stable(pop_data[g]));
        end
    endgenerate

`ifndef BR_FLOW_DEMUX_SELECT_STABLE_DROP_EN
    a_in_range: assert property (@(posedge clk) disable iff (rst)
        push_valid |-> in_range);
`endif

    // Everything should have drained by the end of simulation.
    final begin
        if (EnableAssertFinalNotValid != 0) begin
            a_final_empty: assert (pop_valid == '0);
        end
    end
endmodule

// File: tb/tb_br_flow_demux_select_stable.sv
// Directed bench: cfg 0 = 4 flows single register, cfg 1 = 4 flows skid buffer,
// cfg 2 = 3 flows single register (out-of-range select). Inactive DUTs see no pushes.
module tb_br_flow_demux_select_stable;
    logic            clk = 1'b0;
    logic            rst;
    logic            push_valid;
    logic [1:0]      push_select;
    logic [7:0]      push_data;
    logic [3:0]      pop_ready;
    logic [1:0]      cfg;

    logic            push_ready_o;
    logic [3:0]      pop_valid_o;
    logic [3:0][7:0] pop_data_o;
    logic            drop_o;

    int n_cmp = 0;
    int n_err = 0;

    br_flow_demux_select_stable_if #(.NumFlows(4), .Width(8)) if_a ();
    br_flow_demux_select_stable_if #(.NumFlows(4), .Width(8)) if_b ();
    br_flow_demux_select_stable_if #(.NumFlows(3), .Width(8)) if_c ();

    assign if_a.push_valid  = push_valid && (cfg == 2'd0);
    assign if_b.push_valid  = push_valid && (cfg == 2'd1);
    assign if_c.push_valid  = push_valid && (cfg == 2'd2);
    assign if_a.push_select = push_select;
    assign if_b.push_select = push_select;
    assign if_c.push_select = push_select;
    assign if_a.push_data   = push_data;
    assign if_b.push_data   = push_data;
    assign if_c.push_data   = push_data;
    assign if_a.pop_ready   = pop_ready;
    assign if_b.pop_ready   = pop_ready;
    assign if_c.pop_ready   = pop_ready[2:0];

    br_flow_demux_select_stable #(.NumFlows(4), .Width(8), .RegisterPopReady(0)) dut_a (
        .clk(clk), .rst(rst), .io(if_a.slave));
    br_flow_demux_select_stable #(.NumFlows(4), .Width(8), .RegisterPopReady(1)) dut_b (
        .clk(clk), .rst(rst), .io(if_b.slave));
    br_flow_demux_select_stable #(.NumFlows(3), .Width(8), .RegisterPopReady(0)) dut_c (
        .clk(clk), .rst(rst), .io(if_c.slave));

    always #5 clk = ~clk;

    always_comb begin
        case (cfg)
            2'd0: begin
                push_ready_o = if_a.push_ready; pop_valid_o = if_a.pop_valid;
                pop_data_o = if_a.pop_data; drop_o = if_a.drop;
            end
            2'd1: begin
                push_ready_o = if_b.push_ready; pop_valid_o = if_b.pop_valid;
                pop_data_o = if_b.pop_data; drop_o = if_b.drop;
            end
            default: begin
                push_ready_o = if_c.push_ready; pop_valid_o = {1'b0, if_c.pop_valid};
                pop_data_o = {8'h00, if_c.pop_data}; drop_o = if_c.drop;
            end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            cfg = 2'(c);
            #1;
            n_cmp++; if (push_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_push_ready cfg%0d: got %b expected 0", c, push_ready_o); end
            n_cmp++; if (pop_valid_o !== 4'b0000) begin n_err++; $display("FAIL reset_pop_valid cfg%0d: got %b expected 0000", c, pop_valid_o); end
            n_cmp++; if (pop_data_o !== 32'h0) begin n_err++; $display("FAIL reset_pop_data cfg%0d: got %h expected 0", c, pop_data_o); end
            n_cmp++; if (drop_o !== 1'b0) begin n_err++; $display("FAIL reset_drop cfg%0d: got %b expected 0", c, drop_o); end
        end
    endtask

    task automatic test_basic(input logic [1:0] c);
        cfg = c; pop_ready = 4'hF;
        push_valid = 1'b1; push_select = 2'd2; push_data = 8'hA5;
        #1;
        n_cmp++; if (push_ready_o !== 1'b1) begin n_err++; $display("FAIL basic_ready cfg%0d: got %b expected 1", c, push_ready_o); end
        tick();
        push_valid = 1'b0;
        n_cmp++; if (pop_valid_o !== 4'b0100) begin n_err++; $display("FAIL basic_valid cfg%0d: got %b expected 0100", c, pop_valid_o); end
        n_cmp++; if (pop_data_o[2] !== 8'hA5) begin n_err++; $display("FAIL basic_data cfg%0d: got %h expected a5", c, pop_data_o[2]); end
        tick();
        n_cmp++; if (pop_valid_o !== 4'b0000) begin n_err++; $display("FAIL basic_drain cfg%0d: got %b expected 0000", c, pop_valid_o); end
    endtask

    task automatic test_stall(input logic [1:0] c);
        cfg = c; pop_ready = 4'b1101;
        push_valid = 1'b1; push_select = 2'd1; push_data = 8'h11;
        tick();
        push_data = 8'h22;
        #1;
        if (c == 2'd0) begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++; if (push_ready_o !== 1'b0) begin n_err++; $display("FAIL stall_ready_low cfg%0d: got %b expected 0", c, push_ready_o); end
                n_cmp++; if (pop_data_o[1] !== 8'h11) begin n_err++; $display("FAIL stall_hold cfg%0d: got %h expected 11", c, pop_data_o[1]); end
                tick();
            end
            pop_ready = 4'hF;
            #1;
            n_cmp++; if (push_ready_o !== 1'b1) begin n_err++; $display("FAIL stall_ready_release cfg%0d: got %b expected 1", c, push_ready_o); end
        end else begin
            n_cmp++; if (push_ready_o !== 1'b1) begin n_err++; $display("FAIL skid_accept cfg%0d: got %b expected 1", c, push_ready_o); end
            tick();
            push_valid = 1'b0;
            n_cmp++; if (push_ready_o !== 1'b0) begin n_err++; $display("FAIL skid_full cfg%0d: got %b expected 0", c, push_ready_o); end
            pop_ready = 4'hF;
            #1;
            n_cmp++; if (push_ready_o !== 1'b0) begin n_err++; $display("FAIL skid_full_pop cfg%0d: got %b expected 0", c, push_ready_o); end
        end
        n_cmp++; if (pop_valid_o[1] !== 1'b1 || pop_data_o[1] !== 8'h11) begin n_err++; $display("FAIL stall_first cfg%0d: got %b/%h expected 1/11", c, pop_valid_o[1], pop_data_o[1]); end
        tick();
        push_valid = 1'b0;
        n_cmp++; if (pop_valid_o[1] !== 1'b1 || pop_data_o[1] !== 8'h22) begin n_err++; $display("FAIL stall_second cfg%0d: got %b/%h expected 1/22", c, pop_valid_o[1], pop_data_o[1]); end
        n_cmp++; if (push_ready_o !== 1'b1) begin n_err++; $display("FAIL stall_ready_after cfg%0d: got %b expected 1", c, push_ready_o); end
        tick();
        n_cmp++; if (pop_valid_o !== 4'b0000) begin n_err++; $display("FAIL stall_drain cfg%0d: got %b expected 0000", c, pop_valid_o); end
    endtask

    task automatic test_independent(input logic [1:0] c);
        cfg = c; pop_ready = 4'b1110;
        push_valid = 1'b1; push_select = 2'd0; push_data = 8'h44;
        tick();
        if (c == 2'd1) begin
            push_data = 8'h55;
            tick();
        end
        push_select = 2'd3; push_data = 8'h33;
        #1;
        n_cmp++; if (push_ready_o !== 1'b1) begin n_err++; $display("FAIL indep_ready cfg%0d: got %b expected 1", c, push_ready_o); end
        tick();
        push_valid = 1'b0;
        n_cmp++; if (pop_valid_o !== 4'b1001) begin n_err++; $display("FAIL indep_valid cfg%0d: got %b expected 1001", c, pop_valid_o); end
        n_cmp++; if (pop_data_o[3] !== 8'h33 || pop_data_o[0] !== 8'h44) begin n_err++; $display("FAIL indep_data cfg%0d: got %h/%h expected 33/44", c, pop_data_o[3], pop_data_o[0]); end
        tick();
        n_cmp++; if (pop_valid_o !== 4'b0001 || pop_data_o[0] !== 8'h44) begin n_err++; $display("FAIL indep_out0 cfg%0d: got %b/%h expected 0001/44", c, pop_valid_o, pop_data_o[0]); end
        pop_ready = 4'hF;
        tick();
        if (c == 2'd1) begin
            n_cmp++; if (pop_valid_o !== 4'b0001 || pop_data_o[0] !== 8'h55) begin n_err++; $display("FAIL indep_tail cfg%0d: got %b/%h expected 0001/55", c, pop_valid_o, pop_data_o[0]); end
            tick();
        end
        n_cmp++; if (pop_valid_o !== 4'b0000) begin n_err++; $display("FAIL indep_drain cfg%0d: got %b expected 0000", c, pop_valid_o); end
    endtask

    task automatic test_back_to_back(input logic [1:0] c);
        logic [7:0] exp_d;
        cfg = c; pop_ready = 4'hF;
        for (int k = 0; k < 16; k++) begin
            exp_d = 8'h80 + 8'(k);
            push_valid = 1'b1; push_select = 2'd1; push_data = exp_d;
            #1;
            n_cmp++; if (push_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready cfg%0d beat%0d: got %b expected 1", c, k, push_ready_o); end
            tick();
            n_cmp++; if (pop_valid_o !== 4'b0010 || pop_data_o[1] !== exp_d) begin n_err++; $display("FAIL b2b_beat cfg%0d beat%0d: got %b/%h expected 0010/%h", c, k, pop_valid_o, pop_data_o[1], exp_d); end
        end
        push_valid = 1'b0;
        tick();
        n_cmp++; if (pop_valid_o !== 4'b0000) begin n_err++; $display("FAIL b2b_drain cfg%0d: got %b expected 0000", c, pop_valid_o); end
    endtask

    task automatic test_out_of_range();
        cfg = 2'd2; pop_ready = 4'hF;
        push_select = 2'd3; push_data = 8'h99;
`ifdef BR_FLOW_DEMUX_SELECT_STABLE_DROP_EN
        push_valid = 1'b1;
        #1;
        n_cmp++; if (push_ready_o !== 1'b1) begin n_err++; $display("FAIL oor_ready: got %b expected 1", push_ready_o); end
        tick();
        push_valid = 1'b0;
        n_cmp++; if (drop_o !== 1'b1) begin n_err++; $display("FAIL oor_drop: got %b expected 1", drop_o); end
        n_cmp++; if (pop_valid_o !== 4'b0000) begin n_err++; $display("FAIL oor_no_valid: got %b expected 0000", pop_valid_o); end
        tick();
        n_cmp++; if (drop_o !== 1'b0) begin n_err++; $display("FAIL oor_drop_pulse: got %b expected 0", drop_o); end
`else
        push_valid = 1'b0;
        #1;
        n_cmp++; if (push_ready_o !== 1'b0) begin n_err++; $display("FAIL oor_ready: got %b expected 0", push_ready_o); end
        tick();
        n_cmp++; if (drop_o !== 1'b0) begin n_err++; $display("FAIL oor_drop_tied: got %b expected 0", drop_o); end
`endif
        push_valid = 1'b1; push_select = 2'd2; push_data = 8'h77;
        #1;
        n_cmp++; if (push_ready_o !== 1'b1) begin n_err++; $display("FAIL n3_ready: got %b expected 1", push_ready_o); end
        tick();
        push_valid = 1'b0;
        n_cmp++; if (pop_valid_o !== 4'b0100 || pop_data_o[2] !== 8'h77) begin n_err++; $display("FAIL n3_deliver: got %b/%h expected 0100/77", pop_valid_o, pop_data_o[2]); end
        tick();
    endtask

    task automatic test_reset_mid();
        cfg = 2'd0; pop_ready = 4'h0;
        push_valid = 1'b1; push_select = 2'd0; push_data = 8'h01;
        tick();
        push_select = 2'd2; push_data = 8'h02;
        tick();
        push_valid = 1'b0;
        n_cmp++; if (pop_valid_o !== 4'b0101) begin n_err++; $display("FAIL mid_before: got %b expected 0101", pop_valid_o); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (pop_valid_o !== 4'b0000) begin n_err++; $display("FAIL mid_async_clear: got %b expected 0000", pop_valid_o); end
        n_cmp++; if (push_ready_o !== 1'b0) begin n_err++; $display("FAIL mid_ready_in_reset: got %b expected 0", push_ready_o); end
        tick();
        rst = 1'b0;
        pop_ready = 4'hF;
        push_valid = 1'b1; push_select = 2'd0; push_data = 8'h5A;
        #1;
        n_cmp++; if (push_ready_o !== 1'b1) begin n_err++; $display("FAIL mid_first_ready: got %b expected 1", push_ready_o); end
        tick();
        push_valid = 1'b0;
        n_cmp++; if (pop_valid_o !== 4'b0001 || pop_data_o[0] !== 8'h5A) begin n_err++; $display("FAIL mid_first_beat: got %b/%h expected 0001/5a", pop_valid_o, pop_data_o[0]); end
        tick();
    endtask

    initial begin
        rst = 1'b1; push_valid = 1'b0; push_select = 2'd0; push_data = 8'h00;
        pop_ready = 4'h0; cfg = 2'd0;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        for (int c = 0; c < 2; c++) test_basic(2'(c));
        for (int c = 0; c < 2; c++) test_stall(2'(c));
        for (int c = 0; c < 2; c++) test_independent(2'(c));
        for (int c = 0; c < 2; c++) test_back_to_back(2'(c));
        test_out_of_range();
        test_reset_mid();
        pop_ready = 4'hF;
        tick();
        tick();
        tick();
        for (int c = 0; c < 3; c++) begin
            cfg = 2'(c);
            #1;
            n_cmp++; if (pop_valid_o !== 4'b0000) begin n_err++; $display("FAIL final_empty cfg%0d: got %b expected 0000", c, pop_valid_o); end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
